// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the chunked serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 1;
  endfunction

  // Chunk counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (width >= 2) && (width <= 64) && (chunk >= 1) &&
           (chunk <= width) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/fullsub_chunk.sv
// CHUNK-bit ripple of full subtractors; one slice of the serial datapath.
module fullsub_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bi,
  output logic [CHUNK-1:0] diff,
  output logic             bo
);

  logic [CHUNK:0] br;

  assign br[0] = bi;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign diff[gi]  = a[gi] ^ b[gi] ^ br[gi];
    assign br[gi+1]  = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & br[gi]);
  end

  assign bo = br[CHUNK];

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: D = A - B - bin, CHUNK bits per cycle, with borrow and signed overflow.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("serial_sub: WIDTH must be 2..64 and a multiple of CHUNK");
  end

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic [CHUNK-1:0] diff_cur;
  logic             bo_cur;
  logic [WIDTH-1:0] d_next;
  logic             last_chunk;

  // Counter-selected operand slice; constant offsets keep this a plain mux.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_cur = a_reg[i*CHUNK +: CHUNK];
        b_cur = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    d_next = d_reg;
    for (int i = 0; i < N; i++) begin
      if (cnt_reg == CW'(i)) begin
        d_next[i*CHUNK +: CHUNK] = diff_cur;
      end
    end
  end

  fullsub_chunk #(
    .CHUNK (CHUNK)
  ) u_fullsub (
    .a    (a_cur),
    .b    (b_cur),
    .bi   (borrow_reg),
    .diff (diff_cur),
    .bo   (bo_cur)
  );

  assign last_chunk = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_reg      <= A;
            b_reg      <= B;
            borrow_reg <= bin;
            cnt_reg    <= '0;
            d_reg      <= '0;
            bout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RUN;
          end else begin
            state_reg  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          d_reg      <= d_next;
          borrow_reg <= bo_cur;
          if (last_chunk) begin
            // The last slice carries the MSB of D, so overflow is decided here.
            bout_reg  <= bo_cur;
            ovf_reg   <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                         (diff_cur[CHUNK-1] ^ a_reg[WIDTH-1]);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg   <= cnt_reg + CW'(1);
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign D    = d_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub across several WIDTH/CHUNK configurations.
module tb_serial_sub;

  localparam int NI = 5;
  localparam int CFG_W [NI] = '{8, 8, 4, 4, 4};
  localparam int CFG_C [NI] = '{1, 4, 1, 2, 4};

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    int         exp_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n  [NI];
  logic       start  [NI];
  logic [7:0] a_s    [NI];
  logic [7:0] b_s    [NI];
  logic       bin_s  [NI];
  logic       busy_s [NI];
  logic       done_s [NI];
  logic       bout_s [NI];
  logic       ovf_s  [NI];
  logic [7:0] d_s    [NI];

  exp_t       sb [NI][$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] held_d    [NI];
  logic       held_bout [NI];
  logic       held_ovf  [NI];
  int         runlen    [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = CFG_W[gi];
    localparam int C = CFG_C[gi];
    logic [W-1:0] d_loc;

    serial_sub #(
      .WIDTH (W),
      .CHUNK (C)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n[gi]),
      .start (start[gi]),
      .A     (a_s[gi][W-1:0]),
      .B     (b_s[gi][W-1:0]),
      .bin   (bin_s[gi]),
      .busy  (busy_s[gi]),
      .done  (done_s[gi]),
      .D     (d_loc),
      .bout  (bout_s[gi]),
      .ovf   (ovf_s[gi])
    );

    assign d_s[gi] = 8'(d_loc);
  end

  function automatic int nch(input int k);
    return CFG_W[k] / CFG_C[k];
  endfunction

  // Reference: plain integer subtraction reduced modulo 2^W.
  function automatic exp_t model(input int k, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin);
    exp_t       e;
    int         w;
    int         full;
    logic [7:0] dm;
    w    = CFG_W[k];
    full = int'(a) - int'(b) - (bin ? 1 : 0);
    dm   = 8'(full & ((1 << w) - 1));
    e.a       = a;
    e.b       = b;
    e.bin     = bin;
    e.d       = dm;
    e.bout    = (full < 0);
    e.ovf     = (a[w-1] != b[w-1]) && (dm[w-1] != a[w-1]);
    e.exp_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  // Monitor: all comparisons live here, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic overdue;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n[k]) begin
        chk("reset_outputs", k, {busy_s[k], done_s[k], bout_s[k], ovf_s[k], d_s[k]}, 64'd0);
        held_d[k]    = 8'd0;
        held_bout[k] = 1'b0;
        held_ovf[k]  = 1'b0;
        runlen[k]    = 0;
      end else begin
        if (busy_s[k]) runlen[k]++;
        if (done_s[k]) begin
          chk("done_expected", k, 64'(sb[k].size() > 0), 64'd1);
          if (sb[k].size() > 0) begin
            e = sb[k].pop_front();
            chk("D", k, 64'(d_s[k]), 64'(e.d));
            chk("bout", k, 64'(bout_s[k]), 64'(e.bout));
            chk("ovf", k, 64'(ovf_s[k]), 64'(e.ovf));
            chk("latency", k, 64'(cyc), 64'(e.exp_cyc));
            chk("busy_cycles", k, 64'(runlen[k]), 64'(nch(k)));
            held_d[k]    = e.d;
            held_bout[k] = e.bout;
            held_ovf[k]  = e.ovf;
            $display("dut%0d W=%0d C=%0d: %0h - %0h - %0d -> D=%0h bout=%0d ovf=%0d",
                     k, CFG_W[k], CFG_C[k], e.a, e.b, e.bin, d_s[k], bout_s[k], ovf_s[k]);
          end
          runlen[k] = 0;
        end else if (!busy_s[k]) begin
          chk("held_result", k, {d_s[k], bout_s[k], ovf_s[k]},
              {held_d[k], held_bout[k], held_ovf[k]});
        end
        if (sb[k].size() > 0) begin
          overdue = (cyc > sb[k][0].exp_cyc);
          chk("done_deadline", k, 64'(overdue), 64'd0);
          if (overdue) void'(sb[k].pop_front());
        end
      end
    end
  end

  task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t       e;
    logic [7:0] m;
    m        = 8'((1 << CFG_W[k]) - 1);
    a_s[k]   = a & m;
    b_s[k]   = b & m;
    bin_s[k] = bin;
    start[k] = 1'b1;
    e = model(k, a & m, b & m, bin);
    e.exp_cyc = cyc + 1 + nch(k);
    sb[k].push_back(e);
  endtask

  // Drop start, scramble the operand pins, then wait (bounded) for the result.
  task automatic settle(input int k);
    @(negedge clk);
    start[k] = 1'b0;
    a_s[k]   = 8'($urandom);
    b_s[k]   = 8'($urandom);
    bin_s[k] = 1'($urandom);
    for (int t = 0; t < 40 && sb[k].size() != 0; t++) @(negedge clk);
  endtask

  task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    issue(k, a, b, bin);
    settle(k);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      start[k] = 1'b0;
      a_s[k]   = 8'd0;
      b_s[k]   = 8'd0;
      bin_s[k] = 1'b0;
      held_d[k] = 8'd0;
      held_bout[k] = 1'b0;
      held_ovf[k]  = 1'b0;
      runlen[k] = 0;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

    // Directed corner cases, CHUNK=1 and CHUNK=4.
    op(0, 8'h05, 8'h03, 1'b0);
    op(0, 8'h03, 8'h05, 1'b0);
    op(0, 8'h80, 8'h01, 1'b0);
    op(0, 8'h00, 8'h00, 1'b1);
    op(0, 8'hFF, 8'hFF, 1'b0);
    op(1, 8'h00, 8'h00, 1'b1);
    op(1, 8'h80, 8'h01, 1'b0);

    // Back-to-back with start held high through DONE.
    @(negedge clk);
    issue(1, 8'h3C, 8'h1E, 1'b0);
    for (int t = 0; t < 20 && !done_s[1]; t++) @(negedge clk);
    issue(1, 8'h10, 8'h20, 1'b1);
    settle(1);

    // A start pulse during RUN must be ignored.
    @(negedge clk);
    issue(0, 8'h09, 8'h04, 1'b0);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    a_s[0]   = 8'h01;
    b_s[0]   = 8'h01;
    @(negedge clk);
    start[0] = 1'b0;
    for (int t = 0; t < 40 && sb[0].size() != 0; t++) @(negedge clk);

    // Reset in the middle of RUN: outputs clear and no done follows.
    @(negedge clk);
    issue(0, 8'h5A, 8'h33, 1'b0);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    sb[0].delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n[0] = 1'b1;
    repeat (12) @(negedge clk);

    // Randomized operands on the 8-bit configurations.
    for (int i = 0; i < 100; i++) begin
      op(0, 8'($urandom), 8'($urandom), 1'($urandom));
      op(1, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Exhaustive 4-bit sweep for CHUNK = 1, 2, 4.
    for (int k = 2; k < NI; k++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          for (int c = 0; c < 2; c++) begin
            op(k, 8'(a), 8'(b), 1'(c));
          end
        end
      end
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8: operand and difference width in bits; legal range 2..64.
REQ-002 Parameter CHUNK, default 1: bits processed per cycle; WIDTH % CHUNK == 0, else elaboration error.
REQ-003 Derived constant N = WIDTH/CHUNK: number of RUN cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 start  input  1  request; sampled only in IDLE or DONE.
REQ-007 A  input  WIDTH  minuend; captured on accepted start.
REQ-008 B  input  WIDTH  subtrahend; captured on accepted start.
REQ-009 bin  input  1  borrow-in; captured on accepted start.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 D  output  WIDTH  difference A - B - bin, modulo 2^WIDTH.
REQ-013 bout  output  1  borrow out of MSB; 1 when unsigned A < B + bin.
REQ-014 ovf  output  1  signed overflow of the two's-complement subtraction.

Function
REQ-015 FSM states IDLE, RUN, DONE; encoding is implementer's choice.
REQ-016 IDLE: start=1 -> latch A, B, bin, clear chunk counter and D, enter RUN; start=0 -> stay.
REQ-017 RUN: each cycle subtract chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK) with the running borrow, write that D slice, update the borrow register, increment the counter.
REQ-018 RUN -> DONE on the edge that processes chunk N-1.
REQ-019 DONE lasts exactly one cycle: done=1; start=1 -> accept new operands, enter RUN; else enter IDLE.
REQ-020 Latency: start high at edge k -> done high during the cycle after edge k+N.
REQ-021 start is ignored in RUN; latched operands do not change.
REQ-022 D, bout and ovf hold their values from DONE until the next accepted start.
REQ-023 ovf = (A[WIDTH-1] != B[WIDTH-1]) AND (D[WIDTH-1] != A[WIDTH-1]), evaluated on latched operands, valid in DONE.
REQ-024 bout = final borrow register value after chunk N-1.
REQ-025 Chunk counter width = clog2(N), minimum 1 bit; no wrap-around beyond N-1.
REQ-026 A/B/bin changes outside an accepted start have no effect on the result.

Reset
REQ-027 rst_n low, asynchronous: state=IDLE, busy=0, done=0, D=0, bout=0, ovf=0, counter=0, borrow register=0.
REQ-028 Reset mid-RUN discards the operation; no done pulse follows.
REQ-029 First accepted start is the first rising edge with rst_n=1 and start=1.

Structure
REQ-030 Shared package serial_sub_pkg holds the state enum and the N/counter-width helper.
REQ-031 One sub-module, fullsub_chunk (CHUNK-bit ripple of full subtractors: diff = a^b^bi, bo = (~a&b)|(~(a^b)&bi)); instantiated once and reused each cycle.
REQ-032 No multipliers; no combinational WIDTH-wide subtractor.

Verification (WIDTH=8 unless stated)
REQ-033 CHUNK=1: A=5, B=3, bin=0, start pulse -> done 9 edges after start, D=0x02, bout=0, ovf=0.
REQ-034 CHUNK=1: A=3, B=5 -> D=0xFE, bout=1, ovf=0; then A=0x80, B=0x01 -> D=0x7F, bout=0, ovf=1.
REQ-035 A=0, B=0, bin=1 -> D=0xFF, bout=1; A=0xFF, B=0xFF, bin=0 -> D=0x00, bout=0.
REQ-036 CHUNK=4: A=0x3C, B=0x1E -> busy high 2 cycles, done 3 edges after start, D=0x1E; start held high through DONE starts a back-to-back operation with no IDLE cycle.
REQ-037 Start A=9, B=4; pulse start with A=1, B=1 mid-RUN -> ignored, D=0x05; second run with rst_n low mid-RUN -> all outputs 0, no done pulse.
REQ-038 Exhaustive sweep, WIDTH=4, CHUNK in {1,2,4}: all A, B, bin vs. reference model; D, bout, ovf match.
